// File: rtl/corescore_uart_arbiter_if.sv
// Byte-stream bundle between the SERV core array and the shared UART arbiter.
// Core k drives byte lane [8k+7:8k] and valid bit k; the arbiter returns a one-hot ready.
interface corescore_uart_arbiter_if #(
    parameter int NUM_CORES = 16
);
    logic [NUM_CORES*8-1:0] i_tdata;
    logic [NUM_CORES-1:0]   i_tvalid;
    logic [NUM_CORES-1:0]   o_tready;

    modport master (
        output i_tdata,
        output i_tvalid,
        input  o_tready
    );

    modport slave (
        input  i_tdata,
        input  i_tvalid,
        output o_tready
    );
endinterface

// File: rtl/corescore_uart_arbiter.sv
// Round-robin arbiter feeding an 8N1 serializer that shares one UART TX pin among NUM_CORES cores.
// Optional macro CORESCORE_ARB_LINE_LOCK_EN keeps a core granted until it sends 8'h0A.
module corescore_uart_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int CLK_HZ    = 10_000_000,
    parameter int BAUD      = 115_200
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    corescore_uart_arbiter_if.slave      s,
    output logic                         o_uart_tx,
    output logic                         o_busy,
    output logic [$clog2(NUM_CORES)-1:0] o_grant
);
    localparam int GW  = $clog2(NUM_CORES);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    // STOP ends one cycle early: the IDLE/handshake cycle supplies the last stop-bit cycle.
    localparam logic [BW-1:0] STOP_LAST = BW'(DIV - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [GW-1:0]   grant_q;
    logic            rr_vld;
    logic [GW-1:0]   rr_idx;
    logic            win_vld;
    logic [GW-1:0]   win_idx;
    logic [7:0]      win_byte;
    logic            accept;
    logic            bit_end;

    // Search grant+1, grant+2, ... wrapping; descending loop lets the nearest requester win.
    always_comb begin
        int            j;
        logic [GW-1:0] cand;
        rr_vld = 1'b0;
        rr_idx = grant_q;
        j      = 0;
        cand   = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            j = int'(grant_q) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            cand = GW'(j);
            if (s.i_tvalid[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

`ifdef CORESCORE_ARB_LINE_LOCK_EN
    logic          lock_q;
    logic [GW-1:0] lock_idx_q;

    assign win_vld = lock_q ? s.i_tvalid[lock_idx_q] : rr_vld;
    assign win_idx = lock_q ? lock_idx_q : rr_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            lock_q     <= (win_byte != 8'h0A);
            lock_idx_q <= win_idx;
        end
    end
`else
    assign win_vld = rr_vld;
    assign win_idx = rr_idx;
`endif

    assign win_byte = s.i_tdata[{win_idx, 3'b000} +: 8];
    assign accept   = (state_q == IDLE) && win_vld;
    assign bit_end  = (state_q == STOP) ? (baud_cnt_q == STOP_LAST)
                                        : (baud_cnt_q == BAUD_LAST);
    assign o_grant  = grant_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_cnt_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            grant_q    <= GW'(NUM_CORES - 1);
        end else begin
            if ((state_q == IDLE) || bit_end) baud_cnt_q <= '0;
            else                              baud_cnt_q <= baud_cnt_q + 1'b1;
            if (state_q != DATA) bit_cnt_q <= '0;
            else if (bit_end)    bit_cnt_q <= bit_cnt_q + 1'b1;
            if (accept) grant_q <= win_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) shreg_q <= win_byte;
    end

    // Ready is gated by reset so no core sees an accept while the arbiter is held.
    always_comb begin
        s.o_tready = '0;
        o_uart_tx  = 1'b1;
        o_busy     = (state_q != IDLE);
        case (state_q)
            START:   o_uart_tx = 1'b0;
            DATA:    o_uart_tx = shreg_q[bit_cnt_q];
            default: o_uart_tx = 1'b1;
        endcase
        if (accept && !i_rst) s.o_tready[win_idx] = 1'b1;
    end
endmodule

// File: tb/tb_corescore_uart_arbiter.sv
// Randomized bench for corescore_uart_arbiter against a per-core queue / frame-timing model.
// Honours CORESCORE_ARB_LINE_LOCK_EN in the model when the macro is defined.
module tb_corescore_uart_arbiter;
    localparam int NC     = 16;
    localparam int CLK_HZ = 10_000_000;
    localparam int BAUD   = 115_200;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int GW     = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx;
    logic          busy;
    logic [GW-1:0] grant;

    always #5 clk = ~clk;

    corescore_uart_arbiter_if #(.NUM_CORES(NC)) bus ();

    corescore_uart_arbiter #(
        .NUM_CORES (NC),
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .s         (bus),
        .o_uart_tx (tx),
        .o_busy    (busy),
        .o_grant   (grant)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] q [NC][$];
    int         obs_order[$];

    int         m_grant;
    int         m_next_free;
    int         m_start;
    logic [7:0] m_byte;
    bit         m_lock;
    int         m_lock_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_grant     = NC - 1;
        m_next_free = cyc;
        m_start     = -1;
        m_lock      = 1'b0;
        m_lock_idx  = 0;
    endfunction

    function automatic int model_winner(input logic [NC-1:0] v);
        if (m_lock) return v[m_lock_idx] ? m_lock_idx : -1;
        for (int i = 1; i <= NC; i++) begin
            int j;
            j = (m_grant + i) % NC;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic exp_tx();
        int off;
        if (m_start < 0) return 1'b1;
        off = cyc - m_start;
        if (off < 0)       return 1'b1;
        if (off < DIV)     return 1'b0;
        if (off < 9 * DIV) return 1'((m_byte >> ((off - DIV) / DIV)) & 8'h01);
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        int off;
        if (m_start < 0) return 1'b0;
        off = cyc - m_start;
        return (off >= 0) && (off < 10 * DIV - 1);
    endfunction

    function automatic int pending();
        int p;
        p = (cyc < m_next_free) ? 1 : 0;
        for (int k = 0; k < NC; k++) p += q[k].size();
        return p;
    endfunction

    task automatic set_inputs();
        for (int k = 0; k < NC; k++) begin
            bus.i_tvalid[k]       = (q[k].size() != 0);
            bus.i_tdata[k*8 +: 8] = (q[k].size() != 0) ? q[k][0] : 8'h00;
        end
    endtask

    // One clock: drive at negedge, check outputs, advance the model on a predicted accept.
    task automatic tick();
        logic [NC-1:0] v;
        logic [NC-1:0] exp_rdy;
        int            w;
        set_inputs();
        v = bus.i_tvalid;
        #1;
        w       = (cyc >= m_next_free) ? model_winner(v) : -1;
        exp_rdy = (w >= 0) ? (NC'(1) << w) : '0;
        chk("tready", 32'(bus.o_tready), 32'(exp_rdy));
        chk("tx",     32'(tx),           32'(exp_tx()));
        chk("busy",   32'(busy),         32'(exp_busy()));
        chk("grant",  32'(grant),        32'(m_grant));
        for (int k = 0; k < NC; k++)
            if (bus.o_tready[k] && v[k]) obs_order.push_back(k);
        if (w >= 0) begin
            m_byte      = q[w].pop_front();
            m_start     = cyc + 1;
            m_next_free = cyc + 10 * DIV;
            m_grant     = w;
            m_lock      = (m_byte != 8'h0A);
            m_lock_idx  = w;
`ifndef CORESCORE_ARB_LINE_LOCK_EN
            m_lock      = 1'b0;
`endif
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (pending() != 0 && b > 0) begin
`ifdef CORESCORE_ARB_LINE_LOCK_EN
            if (m_lock && q[m_lock_idx].size() == 0 && cyc >= m_next_free)
                q[m_lock_idx].push_back(8'h0A);
`endif
            tick();
            b--;
        end
        chk("drain_pending", pending(), 0);
    endtask

    // Reset asserted between clock edges; outputs must drop to idle before any edge.
    task automatic pulse_reset();
        set_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tx",     32'(tx),            1);
        chk("rst_busy",   32'(busy),          0);
        chk("rst_tready", 32'(bus.o_tready),  0);
        chk("rst_grant",  32'(grant),         NC - 1);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp5[6];
        bus.i_tvalid = '0;
        bus.i_tdata  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("init_tx",     32'(tx),           1);
        chk("init_busy",   32'(busy),         0);
        chk("init_tready", 32'(bus.o_tready), 0);
        chk("init_grant",  32'(grant),        NC - 1);
        rst = 1'b0;
        @(negedge clk);
        model_reset();

        // Single byte 'A' from core 3
        obs_order.delete();
        q[3].push_back(8'h41);
        drain(12 * DIV);
        chk("t1_len", obs_order.size(), 1);
        if (obs_order.size() >= 1) chk("t1_core", obs_order[0], 3);

        // All cores requesting, back-to-back frames
        pulse_reset();
        obs_order.delete();
        for (int k = 0; k < NC; k++) q[k].push_back(8'(k));
        q[0].push_back(8'h00);
        drain(18 * 10 * DIV);
`ifndef CORESCORE_ARB_LINE_LOCK_EN
        chk("t2_len", obs_order.size(), NC + 1);
        for (int i = 0; i < obs_order.size(); i++) chk("t2_order", obs_order[i], i % NC);
`endif

        // Pointer wrap: 15, then 0 beats 14
        pulse_reset();
        obs_order.delete();
        q[15].push_back(8'h0A);
        tick();
        q[0].push_back(8'h0A);
        q[14].push_back(8'h0A);
        drain(4 * 10 * DIV);
        chk("t3_len", obs_order.size(), 3);
        if (obs_order.size() == 3) begin
            chk("t3_first",  obs_order[0], 15);
            chk("t3_second", obs_order[1], 0);
            chk("t3_third",  obs_order[2], 14);
        end

        // Reset during DATA bit 4, then core 0 wins over core 12
        pulse_reset();
        q[9].push_back(8'hA5);
        tick();
        q[0].push_back(8'h0A);
        q[12].push_back(8'h0A);
        for (int b = 0; b < 2000 && (cyc - m_start) < 5 * DIV + DIV / 2; b++) tick();
        chk("t4_in_bit4", 32'((cyc - m_start) / DIV), 5);
        obs_order.delete();
        pulse_reset();
        drain(4 * 10 * DIV);
        chk("t4_len", obs_order.size(), 2);
        if (obs_order.size() == 2) begin
            chk("t4_first",  obs_order[0], 0);
            chk("t4_second", obs_order[1], 12);
        end

        // Core 2 sends "AB\n" while core 5 keeps requesting
        pulse_reset();
        obs_order.delete();
        q[2].push_back(8'h41);
        q[2].push_back(8'h42);
        q[2].push_back(8'h0A);
        for (int i = 0; i < 3; i++) q[5].push_back(8'h35);
`ifdef CORESCORE_ARB_LINE_LOCK_EN
        exp5 = '{2, 2, 2, 5, 5, 5};
`else
        exp5 = '{2, 5, 2, 5, 2, 5};
`endif
        drain(9 * 10 * DIV);
        chk("t5_len_ok", 32'(obs_order.size() >= 6), 1);
        if (obs_order.size() >= 6)
            for (int i = 0; i < 6; i++) chk("t5_order", obs_order[i], exp5[i]);

        // Idle line
        repeat (1000) tick();

        // Random traffic
        pulse_reset();
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                int k;
                k = $urandom_range(0, NC - 1);
                if (q[k].size() < 3)
                    q[k].push_back(($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255)));
            end
            tick();
        end
        drain(30 * 10 * DIV);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
